uart_baudgen: RTL and testbench
===============================

# uart_baudgen

Baud-rate generator for the UART 16750 core. Divides CLK by the programmed 16-bit divisor latch (DLM:DLL) to produce the 16x oversampling strobe BAUDTICK. BAUDTICK drives the ENABLE input of the receiver and transmitter sample/bit counters. The block also produces a once-per-bit strobe, BITTICK, and exposes the current oversample phase.

## Interface
- Parameters
  - DIV_WIDTH, default 16: divisor width. Divisor values 0..2^DIV_WIDTH-1.
- Ports (one clock; reset is synchronous and active-low)
  - CLK  in  1  system clock; all state changes on its rising edge.
  - RSTN  in  1  synchronous active-low reset.
  - CE  in  1  clock enable; the divider advances only on cycles with CE=1.
  - CLEAR  in  1  synchronous restart of the divider and phase; the divisor is kept.
  - DIV_WR  in  1  single-cycle strobe; captures DIVIDER into the internal divisor register.
  - DIVIDER  in  DIV_WIDTH  new divisor value; sampled only when DIV_WR=1.
  - BAUDTICK  out  1  registered one-cycle pulse at rate CE-cycles/divisor.
  - BITTICK  out  1  registered one-cycle pulse, coincident with every 16th BAUDTICK.
  - PHASE  out  4  number of BAUDTICKs since the last bit boundary, modulo 16.

## Operation
- State
  - div_q[DIV_WIDTH-1:0]: divisor register.
  - cnt[DIV_WIDTH-1:0]: up-counter.
  - phase[3:0].
  - BAUDTICK and BITTICK output registers.
- Reset (RSTN=0 at a clock edge) clears div_q, cnt, phase, BAUDTICK and BITTICK to 0. Reset overrides every other input.
- Priority, highest first: RSTN, then DIV_WR/CLEAR, then normal counting.
- DIV_WR=1: div_q <= DIVIDER, cnt <= 0, phase <= 0, BAUDTICK <= 0, BITTICK <= 0.
- CLEAR=1: cnt <= 0, phase <= 0, BAUDTICK <= 0, BITTICK <= 0; div_q unchanged.
- DIV_WR and CLEAR together: apply the DIV_WR action. Both actions reset the same state, so the result is identical.
- Normal counting (div_q != 0, CE=1):
  - If cnt == div_q-1: cnt <= 0, BAUDTICK <= 1, phase <= phase+1 (wraps 15->0), and BITTICK <= (phase == 15).
  - Otherwise: cnt <= cnt+1, BAUDTICK <= 0, BITTICK <= 0.
- CE=0: cnt and phase hold; BAUDTICK and BITTICK are driven 0, so a pulse is never stretched.
- div_q == 0: generator disabled. cnt and phase hold at their current values; no ticks are produced.
- DIVIDER changes without DIV_WR have no effect.
- Arithmetic: the div_q-1 compare is DIV_WIDTH bits wide and unsigned; it is never evaluated when div_q == 0. cnt never exceeds div_q-1.
- PHASE is phase (registered). It reflects the count after the most recent BAUDTICK.

## Timing
- All outputs are registered; there are no combinational paths from any input to any output.
- With CE held at 1 and divisor N >= 1, BAUDTICK is high exactly 1 cycle in every N. For N=1, BAUDTICK is high every cycle.
- Latency: DIV_WR sampled at edge t gives the first BAUDTICK high in cycle t+N+1. Each subsequent BAUDTICK follows N cycles later.
- Latency: CLEAR sampled at edge t gives the first BAUDTICK high in cycle t+N+1, with the same spacing as above.
- BITTICK fires every 16*N cycles, in the same cycle as the BAUDTICK that wraps PHASE from 15 to 0.
- With CE gated, spacing is counted in CE=1 cycles only.
- Reset mid-count: outputs are 0 in the cycle after the reset edge. After reset deasserts the block stays idle (div_q=0) until a DIV_WR.

## Test plan
- Reset: after RSTN=0 for 2 cycles, then RSTN=1 with no DIV_WR for 100 cycles -> BAUDTICK=0, BITTICK=0, PHASE=0 throughout.
- Divisor 4: DIV_WR with DIVIDER=4 at edge t, CE=1 -> BAUDTICK at cycles t+5, t+9, t+13, ...; first BITTICK at t+65 with PHASE going 15->0; BITTICK period 64.
- Divisor 1, then 0: DIV_WR=1 with DIVIDER=1 -> BAUDTICK continuously high from cycle t+2, BITTICK every 16th cycle. Then DIV_WR with DIVIDER=0 -> no BAUDTICK and no BITTICK for 200 cycles.
- CE gating: divisor 3, CE toggling 1,0,1,0,... -> BAUDTICK spacing is 6 cycles, each pulse exactly 1 cycle wide, and no pulse in any CE=0 cycle.
- CLEAR/DIV_WR mid-count: divisor 10, assert CLEAR when cnt=7 and PHASE=5 -> PHASE=0 next cycle and the next BAUDTICK 11 cycles after the CLEAR edge. Repeat with DIV_WR of 2 -> the new 2-cycle spacing starts 3 cycles after the write.
- Reset mid-operation: divisor 5 running, RSTN=0 for 1 cycle -> BAUDTICK, BITTICK and PHASE are 0 next cycle and stay 0 until a new DIV_WR.

Source files
------------

// File: rtl/uart_baudgen_if.sv
// -----------------------------------------------------------------------------
// uart_baudgen_if
// Control and strobe bundle between the UART core and its baud-rate generator.
//
// Signals:
//   CE        clock enable; the divider advances only when high
//   CLEAR     synchronous restart of divider count and phase (divisor kept)
//   DIV_WR    single-cycle strobe that loads DIVIDER into the divisor register
//   DIVIDER   new divisor value, sampled only while DIV_WR is high
//   BAUDTICK  registered 16x oversampling strobe
//   BITTICK   registered once-per-bit strobe (every 16th BAUDTICK)
//   PHASE     BAUDTICKs since the last bit boundary, modulo 16
//
// Modports:
//   master  the side that programs the divisor and consumes the strobes
//   slave   the baud-rate generator itself
// -----------------------------------------------------------------------------
interface uart_baudgen_if #(
    parameter int DIV_WIDTH = 16
);
    logic                 CE;
    logic                 CLEAR;
    logic                 DIV_WR;
    logic [DIV_WIDTH-1:0] DIVIDER;
    logic                 BAUDTICK;
    logic                 BITTICK;
    logic [3:0]           PHASE;

    modport master (
        output CE,
        output CLEAR,
        output DIV_WR,
        output DIVIDER,
        input  BAUDTICK,
        input  BITTICK,
        input  PHASE
    );

    modport slave (
        input  CE,
        input  CLEAR,
        input  DIV_WR,
        input  DIVIDER,
        output BAUDTICK,
        output BITTICK,
        output PHASE
    );
endinterface

// File: rtl/uart_baudgen.sv
// -----------------------------------------------------------------------------
// uart_baudgen
// Baud-rate generator for the UART 16750 core. Divides CLK by the programmed
// divisor to produce the 16x oversampling strobe BAUDTICK, a once-per-bit
// strobe BITTICK, and the current oversample PHASE.
//
// Ports:
//   CLK   system clock, rising edge
//   RSTN  synchronous active-low reset
//   bus   uart_baudgen_if.slave: CE, CLEAR, DIV_WR, DIVIDER in;
//         BAUDTICK, BITTICK, PHASE out (all registered)
//
// A divisor of 0 disables the generator: count and phase hold, no ticks.
// -----------------------------------------------------------------------------
module uart_baudgen #(
    parameter int DIV_WIDTH = 16
) (
    input  logic           CLK,
    input  logic           RSTN,
    uart_baudgen_if.slave  bus
);

    logic [DIV_WIDTH-1:0] div_q,   div_d;
    logic [DIV_WIDTH-1:0] cnt_q,   cnt_d;
    logic [3:0]           phase_q, phase_d;
    logic                 baud_q,  baud_d;
    logic                 bit_q,   bit_d;

    // Terminal count; only consulted when div_q is non-zero, so the
    // wrap of 0-1 is never used.
    logic [DIV_WIDTH-1:0] div_last;
    assign div_last = div_q - DIV_WIDTH'(1);

    always_comb begin
        div_d   = div_q;
        cnt_d   = cnt_q;
        phase_d = phase_q;
        // Strobes default low so a pulse never lasts more than one cycle,
        // including on CE=0 cycles.
        baud_d  = 1'b0;
        bit_d   = 1'b0;

        if (bus.DIV_WR) begin
            // A simultaneous CLEAR resets the same state, so it is subsumed.
            div_d   = bus.DIVIDER;
            cnt_d   = '0;
            phase_d = '0;
        end else if (bus.CLEAR) begin
            cnt_d   = '0;
            phase_d = '0;
        end else if (bus.CE && (div_q != '0)) begin
            if (cnt_q == div_last) begin
                cnt_d   = '0;
                baud_d  = 1'b1;
                phase_d = phase_q + 4'd1;
                // The tick that wraps phase 15 -> 0 marks the bit boundary.
                bit_d   = (phase_q == 4'd15);
            end else begin
                cnt_d   = cnt_q + DIV_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            div_q   <= '0;
            cnt_q   <= '0;
            phase_q <= '0;
            baud_q  <= 1'b0;
            bit_q   <= 1'b0;
        end else begin
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
        end
    end

    assign bus.BAUDTICK = baud_q;
    assign bus.BITTICK  = bit_q;
    assign bus.PHASE    = phase_q;

endmodule

// File: tb/tb_uart_baudgen.sv
// -----------------------------------------------------------------------------
// tb_uart_baudgen
// Directed bench for uart_baudgen. Inputs are driven 1 time unit after each
// rising edge and outputs are sampled at the same point, so the value seen
// after step k reflects the state loaded at edge k.
// -----------------------------------------------------------------------------
module tb_uart_baudgen;

    localparam int W = 16;

    logic clk;
    logic rstn;

    int total = 0;
    int bad   = 0;

    uart_baudgen_if #(.DIV_WIDTH(W)) bus_if ();

    uart_baudgen #(.DIV_WIDTH(W)) dut (
        .CLK  (clk),
        .RSTN (rstn),
        .bus  (bus_if)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Loads a divisor; returns just after the write edge (edge t).
    task automatic write_div(input logic [W-1:0] v);
        bus_if.DIVIDER = v;
        bus_if.DIV_WR  = 1'b1;
        step();
        bus_if.DIV_WR  = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_baud"},  32'(bus_if.BAUDTICK), 32'd0);
        check({tag, "_bit"},   32'(bus_if.BITTICK),  32'd0);
        check({tag, "_phase"}, 32'(bus_if.PHASE),    32'd0);
    endtask

    // Runs n cycles and counts any cycle with a tick or non-zero phase.
    task automatic run_quiet(input string tag, input int n);
        int busy;
        busy = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (bus_if.BAUDTICK || bus_if.BITTICK || (bus_if.PHASE != 4'd0))
                busy++;
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rstn           = 1'b0;
        bus_if.CE      = 1'b1;
        bus_if.CLEAR   = 1'b0;
        bus_if.DIV_WR  = 1'b0;
        bus_if.DIVIDER = '0;

        // Reset for two cycles, then idle with no divisor programmed.
        step();
        step();
        check_idle("rst");
        rstn = 1'b1;
        run_quiet("rst_idle100", 100);

        // Divisor 4: ticks at k = 4, 8, ...; BITTICK at k = 64, 128.
        write_div(16'd4);
        check_idle("d4_wr");
        for (int k = 1; k <= 140; k++) begin
            step();
            check("d4_baud",  32'(bus_if.BAUDTICK), 32'((k % 4) == 0));
            check("d4_bit",   32'(bus_if.BITTICK),  32'((k % 64) == 0));
            check("d4_phase", 32'(bus_if.PHASE),    32'((k / 4) % 16));
        end

        // Divisor 1: BAUDTICK every cycle from k = 1, BITTICK every 16th.
        write_div(16'd1);
        for (int k = 1; k <= 40; k++) begin
            step();
            check("d1_baud",  32'(bus_if.BAUDTICK), 32'd1);
            check("d1_bit",   32'(bus_if.BITTICK),  32'((k % 16) == 0));
            check("d1_phase", 32'(bus_if.PHASE),    32'(k % 16));
        end

        // Divisor 0: disabled.
        write_div(16'd0);
        check_idle("d0_wr");
        run_quiet("d0_quiet200", 200);

        // CE gating with divisor 3: CE high only on odd steps, so ticks land
        // on steps 5, 11, 17, ... (every 6 cycles, never on a CE=0 edge).
        write_div(16'd3);
        for (int k = 1; k <= 60; k++) begin
            bus_if.CE = (k % 2) == 1;
            step();
            check("ce_baud", 32'(bus_if.BAUDTICK), 32'((k % 6) == 5));
            check("ce_bit",  32'(bus_if.BITTICK),  32'd0);
        end
        bus_if.CE = 1'b1;

        // CLEAR mid-count with divisor 10: after 57 cycles cnt=7, phase=5.
        write_div(16'd10);
        for (int k = 1; k <= 57; k++) step();
        check("clr_pre_phase", 32'(bus_if.PHASE), 32'd5);
        bus_if.DIVIDER = 16'd7;     // must be ignored without DIV_WR
        bus_if.CLEAR   = 1'b1;
        step();
        bus_if.CLEAR   = 1'b0;
        check_idle("clr_edge");
        for (int k = 1; k <= 12; k++) begin
            step();
            check("clr_baud", 32'(bus_if.BAUDTICK), 32'(k == 10));
        end
        check("clr_phase_after", 32'(bus_if.PHASE), 32'd1);

        // DIV_WR of 2 mid-count: new 2-cycle spacing from k = 2.
        for (int k = 1; k <= 3; k++) step();
        write_div(16'd2);
        check_idle("wr2_edge");
        for (int k = 1; k <= 8; k++) begin
            step();
            check("wr2_baud",  32'(bus_if.BAUDTICK), 32'((k % 2) == 0));
            check("wr2_phase", 32'(bus_if.PHASE),    32'(k / 2));
        end

        // Reset mid-operation with divisor 5 running.
        write_div(16'd5);
        for (int k = 1; k <= 23; k++) step();
        check("rst5_pre_phase", 32'(bus_if.PHASE), 32'd4);
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        check_idle("rst5_edge");
        bus_if.DIVIDER = 16'd3;     // no DIV_WR: stays idle
        run_quiet("rst5_quiet100", 100);

        // Recovery after reset requires a fresh write.
        write_div(16'd5);
        for (int k = 1; k <= 10; k++) begin
            step();
            check("rec_baud", 32'(bus_if.BAUDTICK), 32'((k % 5) == 0));
        end

        // CLEAR and DIV_WR together: the write wins, spacing 3 from k = 3.
        bus_if.CLEAR = 1'b1;
        write_div(16'd3);
        bus_if.CLEAR = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            step();
            check("both_baud", 32'(bus_if.BAUDTICK), 32'((k % 3) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
